cpu_control_unit: RTL and testbench

Fetch/decode/execute sequencer for the 4-bit CPU. It sits directly upstream of the ALU and owns the program counter, instruction register, accumulator and Zero/Carry flag registers. It reads 8-bit instructions from asynchronous program memory, drives the ALU's A, B and aluOpcode inputs, and writes the ALU result and flags back. It also executes load, jump, output and halt instructions itself.

---
 rtl/cpu_control_unit.sv | 178 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns pc, IR, accumulator and flags, drives the ALU.
// Optional build macro CPU_CTRL_SINGLE_STEP_EN adds a stepReq input that gates each instruction fetch.
module cpu_control_unit #(
    parameter int PC_WIDTH    = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic                stepReq,
`endif
    input  logic [7:0]          instrIn,
    output logic [PC_WIDTH-1:0] pcOut,
    output logic [3:0]          aluA,
    output logic [3:0]          aluB,
    output logic [3:0]          aluOpcode,
    input  logic [3:0]          aluResult,
    input  logic                aluZero,
    input  logic                aluCarry,
    output logic [3:0]          accOut,
    output logic                zeroFlag,
    output logic                carryFlag,
    output logic [3:0]          outPort,
    output logic                outValid,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
    localparam logic [2:0]          LAT_LAST = 3'(ALU_LATENCY - 1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [3:0]          acc_q, acc_d;
    logic                zf_q, zf_d;
    logic                cf_q, cf_d;
    logic [3:0]          alu_a_q, alu_a_d;
    logic [3:0]          alu_b_q, alu_b_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic [3:0]          out_q, out_d;
    logic                out_v_q, out_v_d;
    logic                halt_q, halt_d;
    logic [2:0]          lat_q, lat_d;
    logic                step_ok_s;
    logic [PC_WIDTH-1:0] jmp_tgt_s;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    assign step_ok_s = stepReq;
`else
    assign step_ok_s = 1'b1;
`endif

    assign jmp_tgt_s = PC_WIDTH'(ir_q[3:0]);

    // Next-state and datapath update logic for the instruction sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        out_d    = out_q;
        out_v_d  = 1'b0;
        halt_d   = halt_q;
        lat_d    = lat_q;
        case (state_q)
            S_FETCH: begin
                if (step_ok_s) begin
                    ir_d    = instrIn;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (!ir_q[7]) begin
                    alu_op_d = {1'b0, ir_q[6:4]};
                    alu_a_d  = acc_q;
                    alu_b_d  = ir_q[3:0];
                    lat_d    = 3'd0;
                    state_d  = S_EXECUTE;
                end else begin
                    case (ir_q[6:4])
                        3'b000: acc_d = ir_q[3:0];
                        3'b001: pc_d  = jmp_tgt_s;
                        3'b010: pc_d  = zf_q ? jmp_tgt_s : pc_q;
                        3'b011: pc_d  = cf_q ? jmp_tgt_s : pc_q;
                        3'b100: begin
                            out_d   = acc_q;
                            out_v_d = 1'b1;
                        end
                        3'b111: begin
                            halt_d  = 1'b1;
                            state_d = S_HALT;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECUTE: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = 3'd0;
                    state_d = S_WRITEBACK;
                end else begin
                    lat_d   = lat_q + 3'd1;
                end
            end
            S_WRITEBACK: begin
                acc_d    = aluResult;
                zf_d     = aluZero;
                cf_d     = aluCarry;
                alu_op_d = 4'd0;
                state_d  = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= 8'd0;
            acc_q    <= 4'd0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            alu_a_q  <= 4'd0;
            alu_b_q  <= 4'd0;
            alu_op_q <= 4'd0;
            out_q    <= 4'd0;
            out_v_q  <= 1'b0;
            halt_q   <= 1'b0;
            lat_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            halt_q   <= halt_d;
            lat_q    <= lat_d;
        end
    end

    assign pcOut     = pc_q;
    assign aluA      = alu_a_q;
    assign aluB      = alu_b_q;
    assign aluOpcode = alu_op_q;
    assign accOut    = acc_q;
    assign zeroFlag  = zf_q;
    assign carryFlag = cf_q;
    assign outPort   = out_q;
    assign outValid  = out_v_q;
    assign halted    = halt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: cycle table with scoreboard plus hand-written sequences.
module tb_cpu_control_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       step_req = 1'b1;
    logic [7:0] mem  [16];
    logic [7:0] mem3 [16];
    logic [3:0] alu_res = 4'd0;
    logic       alu_z = 1'b0;
    logic       alu_c = 1'b0;

    logic [3:0] pc, a, b, opc, acc, outp;
    logic       zf, cf, ov, hlt;
    logic [3:0] pc3, a3, b3, opc3, acc3, outp3;
    logic       zf3, cf3, ov3, hlt3;
    logic [7:0] instr, instr3;

    int checks = 0;
    int failures = 0;

    assign instr  = mem[pc];
    assign instr3 = mem3[pc3];

    always #5 clock = ~clock;

    cpu_control_unit #(.PC_WIDTH(4), .ALU_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .stepReq(step_req),
`endif
        .instrIn(instr), .pcOut(pc), .aluA(a), .aluB(b), .aluOpcode(opc),
        .aluResult(alu_res), .aluZero(alu_z), .aluCarry(alu_c),
        .accOut(acc), .zeroFlag(zf), .carryFlag(cf), .outPort(outp),
        .outValid(ov), .halted(hlt)
    );

    cpu_control_unit #(.PC_WIDTH(4), .ALU_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .stepReq(step_req),
`endif
        .instrIn(instr3), .pcOut(pc3), .aluA(a3), .aluB(b3), .aluOpcode(opc3),
        .aluResult(alu_res), .aluZero(alu_z), .aluCarry(alu_c),
        .accOut(acc3), .zeroFlag(zf3), .carryFlag(cf3), .outPort(outp3),
        .outValid(ov3), .halted(hlt3)
    );

    typedef struct {
        logic [3:0] res;
        logic       z;
        logic       c;
        logic [3:0] pc;
        logic [3:0] acc;
        logic [3:0] opc;
        logic [3:0] a;
        logic [3:0] b;
        logic       zf;
        logic       cf;
        logic       hlt;
    } vec_t;

    vec_t tbl [10];
    vec_t sb [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            mem[i]  = v;
            mem3[i] = v;
        end
    endtask

    task automatic run_jz(input logic z, input logic [3:0] exp_pc);
        fill(8'hF0);
        mem[0] = 8'h84; mem[1] = 8'h20; mem[2] = 8'hA5;
        alu_res = 4'h0; alu_z = z; alu_c = 1'b1;
        do_reset();
        repeat (6) tick();
        chk("jz_flag_z", {7'd0, zf}, {7'd0, z});
        chk("jz_flag_c", {7'd0, cf}, 8'd1);
        chk("jz_acc", {4'd0, acc}, 8'd0);
        tick();
        chk("jz_pc_fetch", {4'd0, pc}, 8'd3);
        tick();
        chk("jz_pc_after", {4'd0, pc}, {4'd0, exp_pc});
    endtask

    initial begin
        vec_t e;
        // stub res/z/c driven before each edge; expected outputs after it
        tbl[0] = '{4'h5, 1'b1, 1'b1, 4'd1, 4'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'h5, 1'b1, 1'b1, 4'd1, 4'h9, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{4'h5, 1'b1, 1'b1, 4'd2, 4'h9, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{4'h5, 1'b1, 1'b1, 4'd2, 4'h9, 4'd1, 4'd9, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4'h5, 1'b1, 1'b1, 4'd2, 4'h9, 4'd1, 4'd9, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'hC, 1'b0, 1'b0, 4'd2, 4'hC, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'h5, 1'b1, 1'b1, 4'd3, 4'hC, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{4'h5, 1'b1, 1'b1, 4'd3, 4'hC, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{4'h5, 1'b1, 1'b1, 4'd3, 4'hC, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{4'h5, 1'b1, 1'b1, 4'd3, 4'hC, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0, 1'b1};

        fill(8'hF0);
        mem[0] = 8'h89; mem[1] = 8'h13; mem[2] = 8'hF0;
        do_reset();
        chk("rst_pc", {4'd0, pc}, 8'd0);
        chk("rst_acc", {4'd0, acc}, 8'd0);
        chk("rst_flags", {6'd0, zf, cf}, 8'd0);
        chk("rst_alu", {a, b}, 8'd0);
        chk("rst_opc", {4'd0, opc}, 8'd0);
        chk("rst_out", {3'd0, hlt, ov, outp[2:0]}, 8'd0);

        for (int i = 0; i < 10; i++) begin
            alu_res = tbl[i].res; alu_z = tbl[i].z; alu_c = tbl[i].c;
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("tbl%0d_pc", i), {4'd0, pc}, {4'd0, e.pc});
            chk($sformatf("tbl%0d_acc", i), {4'd0, acc}, {4'd0, e.acc});
            chk($sformatf("tbl%0d_opc", i), {4'd0, opc}, {4'd0, e.opc});
            chk($sformatf("tbl%0d_ab", i), {a, b}, {e.a, e.b});
            chk($sformatf("tbl%0d_flags", i), {6'd0, zf, cf}, {6'd0, e.zf, e.cf});
            chk($sformatf("tbl%0d_halt", i), {7'd0, hlt}, {7'd0, e.hlt});
            chk($sformatf("tbl%0d_ov", i), {7'd0, ov}, 8'd0);
        end

        run_jz(1'b1, 4'd5);
        run_jz(1'b0, 4'd3);

        fill(8'hD0);
        mem[0] = 8'h20; mem[1] = 8'h86; mem[2] = 8'hC0;
        alu_res = 4'h3; alu_z = 1'b1; alu_c = 1'b1;
        do_reset();
        repeat (4) tick();
        chk("out_pre_acc", {4'd0, acc}, 8'd3);
        chk("out_pre_flags", {6'd0, zf, cf}, 8'd3);
        repeat (3) tick();
        chk("out_ldi_acc", {4'd0, acc}, 8'd6);
        chk("out_ov_before", {7'd0, ov}, 8'd0);
        tick();
        chk("out_port", {4'd0, outp}, 8'd6);
        chk("out_ov_pulse", {7'd0, ov}, 8'd1);
        tick();
        chk("out_ov_after", {7'd0, ov}, 8'd0);
        chk("out_port_hold", {4'd0, outp}, 8'd6);
        chk("out_flags_kept", {6'd0, zf, cf}, 8'd3);

        fill(8'hD0);
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            logic [3:0] ep;
            tick();
            ep = 4'((k + 1) / 2);
            if (k % 2 == 1) begin
                chk($sformatf("nop_pc_e%0d", k), {4'd0, pc}, {4'd0, ep});
                chk($sformatf("nop_x_e%0d", k), {7'd0, $isunknown({pc, acc, opc, hlt})}, 8'd0);
                chk($sformatf("nop_halt_e%0d", k), {7'd0, hlt}, 8'd0);
            end
        end

        fill(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h13;
        alu_res = 4'h7; alu_z = 1'b1; alu_c = 1'b1;
        do_reset();
        repeat (6) tick();
        chk("mid_exec_opc", {4'd0, opc}, 8'd1);
        chk("mid_exec_acc", {4'd0, acc}, 8'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pc", {4'd0, pc}, 8'd0);
        chk("mid_rst_acc", {4'd0, acc}, 8'd0);
        chk("mid_rst_flags", {6'd0, zf, cf}, 8'd0);
        chk("mid_rst_opc", {4'd0, opc}, 8'd0);
        chk("mid_rst_ab", {a, b}, 8'd0);
        tick();
        chk("mid_rst_fetch_pc", {4'd0, pc}, 8'd1);
        tick();
        chk("mid_rst_decode_opc", {4'd0, opc}, 8'd2);

        fill(8'hF0);
        mem3[0] = 8'h87; mem3[1] = 8'h13;
        alu_res = 4'hA; alu_z = 1'b0; alu_c = 1'b1;
        do_reset();
        repeat (3) tick();
        for (int k = 4; k <= 7; k++) begin
            tick();
            chk($sformatf("lat3_opc_e%0d", k), {4'd0, opc3}, 8'd1);
            chk($sformatf("lat3_ab_e%0d", k), {a3, b3}, 8'h73);
            chk($sformatf("lat3_acc_e%0d", k), {4'd0, acc3}, 8'd7);
        end
        tick();
        chk("lat3_wb_acc", {4'd0, acc3}, 8'hA);
        chk("lat3_wb_opc", {4'd0, opc3}, 8'd0);
        chk("lat3_wb_flags", {6'd0, zf3, cf3}, 8'd1);
        chk("lat3_wb_ab", {a3, b3}, 8'h73);
        chk("lat3_pc_before_fetch", {4'd0, pc3}, 8'd2);
        tick();
        chk("lat3_next_fetch", {4'd0, pc3}, 8'd3);

`ifdef CPU_CTRL_SINGLE_STEP_EN
        fill(8'hD0);
        step_req = 1'b0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("step_hold_%0d", k), {4'd0, pc}, 8'd0);
        end
        step_req = 1'b1;
        tick();
        chk("step_go", {4'd0, pc}, 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
